// File: rtl/core_pkg.sv
// Shared definitions for the attention-core instruction sequencer.
//   state_e       : sequencer phase enumeration
//   inst bit map  : fixed flag positions (LSB side) plus aw-dependent
//                   field offsets computed by helper functions
//   inst_width()  : total instruction word width for a given aw
package core_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_GAP1,
    S_KLOAD,
    S_GAP2,
    S_EXEC,
    S_GAP3,
    S_DRAIN,
    S_FIN
  } state_e;

  // Flag bits, counted from the LSB of the instruction word.
  localparam int unsigned PMEM_WR      = 0;
  localparam int unsigned PMEM_RD      = 1;
  localparam int unsigned KMEM_WR      = 2;
  localparam int unsigned KMEM_RD      = 3;
  localparam int unsigned QMEM_WR      = 4;
  localparam int unsigned QMEM_RD      = 5;
  localparam int unsigned LOAD         = 6;
  localparam int unsigned EXECUTE      = 7;
  localparam int unsigned PMEM_ADD_LSB = 8;

  function automatic int unsigned inst_width(input int unsigned aw);
    return 2 * aw + 9;
  endfunction

  function automatic int unsigned qkmem_add_lsb(input int unsigned aw);
    return PMEM_ADD_LSB + aw;
  endfunction

  function automatic int unsigned ofifo_rd_pos(input int unsigned aw);
    return 2 * aw + 8;
  endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable up-counter with terminal-count flag.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : increment by one
//   last       : terminal value compared against the current count
//   cnt        : current count
//   tc         : high while cnt == last
module seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/core_inst_seq.sv
// Autonomous instruction sequencer for the attention core.
// A start pulse runs: Q write, K write, gap, K load, gap, execute, gap,
// ofifo-to-pmem drain, then a one-cycle done pulse.
//   clk, reset : clock, synchronous active-high reset
//   start      : begins a run when idle (n_q sampled then)
//   n_q        : Q vectors for the run, clamped to 2^aw
//   in_data    : Q then K vectors on a valid/ready stream
//   in_valid   : in_data valid
//   in_ready   : sequencer accepts in_data (QWR/KWR only)
//   mem_in     : registered data to core
//   inst       : registered instruction word to core
//   busy       : high while a run is in progress
//   done       : one-cycle pulse at run end
//   stall_cnt  : only with CORE_INST_SEQ_STALL_CNT_EN defined; saturating
//                count of QWR/KWR cycles without in_valid
module core_inst_seq
  import core_pkg::*;
#(
  parameter int unsigned bw  = 8,
  parameter int unsigned pr  = 8,
  parameter int unsigned col = 8,
  parameter int unsigned aw  = 4,
  parameter int unsigned gap = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [aw:0]               n_q,
  input  logic [pr*bw-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [pr*bw-1:0]          mem_in,
  output logic [inst_width(aw)-1:0] inst,
  output logic                      busy,
  output logic                      done
`ifdef CORE_INST_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int unsigned IW       = inst_width(aw);
  localparam int unsigned DW       = pr * bw;
  localparam int unsigned QK_LSB   = qkmem_add_lsb(aw);
  localparam int unsigned OFIFO_RD = ofifo_rd_pos(aw);
  // Phase counter must hold both n_q-1 and col+1.
  localparam int unsigned CW = ((aw + 1) > $clog2(col + 2)) ? (aw + 1) : $clog2(col + 2);
  localparam int unsigned GW = (gap > 1) ? $clog2(gap) : 1;
  localparam logic [aw:0] NQ_MAX = {1'b1, {aw{1'b0}}};

  state_e          state_q, state_d;
  logic [aw:0]     n_q_q, n_q_d;
  logic [IW-1:0]   inst_q, inst_d;
  logic [DW-1:0]   mem_in_q, mem_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            ph_load, ph_en, ph_tc;
  logic [CW-1:0]   ph_last, ph_cnt;
  logic            gp_load, gp_en, gp_tc;
  logic [GW-1:0]   gp_cnt_unused;
  logic [aw-1:0]   kl_add;

  seq_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val ('0),
    .en       (ph_en),
    .last     (ph_last),
    .cnt      (ph_cnt),
    .tc       (ph_tc)
  );

  seq_cnt #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gp_load),
    .load_val ('0),
    .en       (gp_en),
    .last     (GW'(gap - 1)),
    .cnt      (gp_cnt_unused),
    .tc       (gp_tc)
  );

  // KLOAD drives qkmem_add = c-1 on cycle c; only the low aw bits matter
  // because c-1 never exceeds col-1.
  assign kl_add = ph_cnt[aw-1:0] - aw'(1);

  always_comb begin
    state_d  = state_q;
    n_q_d    = n_q_q;
    inst_d   = '0;
    mem_in_d = '0;
    done_d   = 1'b0;
    in_ready = 1'b0;
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    ph_last  = '0;
    gp_load  = 1'b0;
    gp_en    = 1'b0;

    // The sequencer never reads pmem; the bit is kept low.
    inst_d[PMEM_RD] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_q_d   = (n_q > NQ_MAX) ? NQ_MAX : n_q;
          state_d = (n_q == '0) ? S_FIN : S_QWR;
          ph_load = 1'b1;
          gp_load = 1'b1;
        end
      end

      S_QWR, S_KWR: begin
        in_ready = 1'b1;
        ph_last  = (state_q == S_QWR) ? (CW'(n_q_q) - CW'(1)) : CW'(col - 1);
        if (in_valid) begin
          inst_d[(state_q == S_QWR) ? QMEM_WR : KMEM_WR] = 1'b1;
          inst_d[QK_LSB +: aw] = ph_cnt[aw-1:0];
          mem_in_d = in_data;
          if (ph_tc) begin
            ph_load = 1'b1;
            state_d = (state_q == S_QWR) ? S_KWR : S_GAP1;
          end else begin
            ph_en = 1'b1;
          end
        end
      end

      S_GAP1, S_GAP2, S_GAP3: begin
        if (gp_tc) begin
          gp_load = 1'b1;
          case (state_q)
            S_GAP1:  state_d = S_KLOAD;
            S_GAP2:  state_d = S_EXEC;
            default: state_d = S_DRAIN;
          endcase
        end else begin
          gp_en = 1'b1;
        end
      end

      S_KLOAD: begin
        ph_last        = CW'(col + 1);
        inst_d[LOAD]   = 1'b1;
        if (ph_cnt >= CW'(1) && ph_cnt <= CW'(col)) begin
          inst_d[KMEM_RD] = 1'b1;
        end
        if (ph_cnt >= CW'(2) && ph_cnt <= CW'(col)) begin
          inst_d[QK_LSB +: aw] = kl_add;
        end
        if (ph_tc) begin
          ph_load = 1'b1;
          state_d = S_GAP2;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_EXEC: begin
        ph_last              = CW'(n_q_q) - CW'(1);
        inst_d[EXECUTE]      = 1'b1;
        inst_d[QMEM_RD]      = 1'b1;
        inst_d[QK_LSB +: aw] = ph_cnt[aw-1:0];
        if (ph_tc) begin
          ph_load = 1'b1;
          state_d = S_GAP3;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_DRAIN: begin
        ph_last                    = CW'(n_q_q) - CW'(1);
        inst_d[OFIFO_RD]           = 1'b1;
        inst_d[PMEM_WR]            = 1'b1;
        inst_d[PMEM_ADD_LSB +: aw] = ph_cnt[aw-1:0];
        if (ph_tc) begin
          ph_load = 1'b1;
          state_d = S_FIN;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q_q    <= '0;
      inst_q   <= '0;
      mem_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q_q    <= n_q_d;
      inst_q   <= inst_d;
      mem_in_q <= mem_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst   = inst_q;
  assign mem_in = mem_in_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef CORE_INST_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if ((state_q == S_QWR || state_q == S_KWR) && !in_valid && stall_q != '1) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
module tb_core_inst_seq;

  localparam int unsigned BW    = 8;
  localparam int unsigned PR    = 8;
  localparam int unsigned COL   = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned GAP   = 10;
  localparam int unsigned DW    = PR * BW;
  localparam int unsigned IW    = 2 * AW + 9;
  localparam int unsigned NQMAX = 1 << AW;

  localparam logic [7:0] F_EXEC = 8'h80;
  localparam logic [7:0] F_LOAD = 8'h40;
  localparam logic [7:0] F_QRD  = 8'h20;
  localparam logic [7:0] F_QWR  = 8'h10;
  localparam logic [7:0] F_KRD  = 8'h08;
  localparam logic [7:0] F_KWR  = 8'h04;
  localparam logic [7:0] F_PWR  = 8'h01;

  typedef struct {
    logic [IW-1:0] inst;
    logic [DW-1:0] mem;
    bit            has_mem;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   n_q;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mem_in;
  logic [IW-1:0] inst;
  logic          busy;
  logic          done;
`ifdef CORE_INST_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  core_inst_seq #(
    .bw  (BW),
    .pr  (PR),
    .col (COL),
    .aw  (AW),
    .gap (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n_q      (n_q),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_in   (mem_in),
    .inst     (inst),
    .busy     (busy),
    .done     (done)
`ifdef CORE_INST_SEQ_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return DW'(v);
  endfunction

  // Instruction word: {ofifo_rd, qkmem_add, pmem_add, 8 flags}
  function automatic logic [IW-1:0] mk(input bit ofifo, input int unsigned qk,
                                       input int unsigned pm, input logic [7:0] fl);
    return {ofifo, AW'(qk), AW'(pm), fl};
  endfunction

  // One run: n_raw requested Q vectors; mode 0 = in_valid always 1,
  // 1 = 3-cycle hole after Q beat 2, 2 = random holes; rst_exec != 0
  // resets the run during that EXEC cycle; poke_drain pulses start in DRAIN.
  task automatic run_seq(input int unsigned n_raw, input int unsigned mode,
                         input int unsigned rst_exec, input bit poke_drain);
    int unsigned n, ones, zeros, b, d_len, k_exec0, k_drain0, total;
    bit          pat[$];
    exp_t        l[$];
    logic [DW-1:0] qv[$];
    logic [DW-1:0] kv[$];
    logic [IW-1:0] e_inst;

    n     = (n_raw > NQMAX) ? NQMAX : n_raw;
    ones  = 0;
    zeros = 0;
    for (int i = 0; i < int'(n); i++) qv.push_back(rand_vec());
    for (int i = 0; i < int'(COL); i++) kv.push_back(rand_vec());

    if (n != 0) begin
      while (ones < n + COL) begin
        bit v;
        case (mode)
          0:       v = 1'b1;
          1:       v = !(pat.size() >= 3 && pat.size() <= 5);
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        pat.push_back(v);
        if (v) ones++; else zeros++;
      end
      b = 0;
      foreach (pat[i]) begin
        if (pat[i]) begin
          if (b < n) l.push_back('{mk(0, b, 0, F_QWR), qv[b], 1'b1});
          else       l.push_back('{mk(0, b - n, 0, F_KWR), kv[b - n], 1'b1});
          b++;
        end else begin
          l.push_back('{'0, '0, 1'b0});
        end
      end
      for (int i = 0; i < int'(GAP); i++) l.push_back('{'0, '0, 1'b0});
      for (int c = 0; c <= int'(COL) + 1; c++) begin
        logic [7:0] fl;
        fl = F_LOAD | ((c >= 1 && c <= int'(COL)) ? F_KRD : 8'h00);
        l.push_back('{mk(0, (c >= 2 && c <= int'(COL)) ? c - 1 : 0, 0, fl), '0, 1'b0});
      end
      for (int i = 0; i < int'(GAP); i++) l.push_back('{'0, '0, 1'b0});
      for (int i = 0; i < int'(n); i++) l.push_back('{mk(0, i, 0, F_EXEC | F_QRD), '0, 1'b0});
      for (int i = 0; i < int'(GAP); i++) l.push_back('{'0, '0, 1'b0});
      for (int i = 0; i < int'(n); i++) l.push_back('{mk(1, 0, i, F_PWR), '0, 1'b0});
    end

    d_len    = pat.size();
    k_exec0  = d_len + GAP + COL + 2 + GAP + 1;
    k_drain0 = k_exec0 + n + GAP;
    total    = l.size();

    n_q      = (AW + 1)'(n_raw);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    b = 0;
    for (int unsigned k = 1; k <= total + 3; k++) begin
      e_inst = (k >= 2 && k - 2 < total) ? l[k - 2].inst : '0;
      chk("inst", 64'(inst), 64'(e_inst));
      chk("busy", 64'(busy), 64'(k <= total + 1));
      chk("done", 64'(done), 64'(k == total + 2));
      chk("in_ready", 64'(in_ready), 64'(k <= d_len));
      if (k >= 2 && k - 2 < total && l[k - 2].has_mem)
        chk("mem_in", 64'(mem_in), 64'(l[k - 2].mem));

      if (rst_exec != 0 && k == k_exec0 + rst_exec) begin
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_mem_in", 64'(mem_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef CORE_INST_SEQ_STALL_CNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_ignored_busy", 64'(busy), 64'd0);
        chk("rst_start_ignored_rdy", 64'(in_ready), 64'd0);
        return;
      end

      start = poke_drain && (k == k_drain0 + 2);
      if (k <= d_len) begin
        in_valid = pat[k - 1];
        if (pat[k - 1]) begin
          in_data = (b < n) ? qv[b] : kv[b - n];
          b++;
        end else begin
          in_data = rand_vec();
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = rand_vec();
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
`ifdef CORE_INST_SEQ_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(zeros));
`endif
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    n_q      = 5'd8;
    in_valid = 1'b1;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", 64'(inst), 64'd0);
    chk("reset_mem_in", 64'(mem_in), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
`ifdef CORE_INST_SEQ_STALL_CNT_EN
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;

    run_seq(8, 0, 0, 1'b0);   // nominal
    run_seq(8, 1, 0, 1'b0);   // 3-cycle stall after Q beat 2
    run_seq(0, 0, 0, 1'b0);   // empty run
    run_seq(20, 2, 0, 1'b0);  // clamped to 16, random stalls
    run_seq(8, 2, 4, 1'b0);   // reset during EXEC cycle 4
    run_seq(8, 0, 0, 1'b0);   // fresh replay after reset
    run_seq(8, 2, 0, 1'b1);   // start during DRAIN ignored
    run_seq(31, 0, 0, 1'b0);  // max n_q input clamps
    repeat (3) run_seq($urandom_range(1, 16), 2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
